// File: rtl/div_issue_pkg.sv
// rtl/div_issue_pkg.sv - shared divide-issue types, latency and div_control encodings
package div_issue_pkg;

  localparam int DIV_LATENCY = 18;
  localparam int DIV_DEPTH   = DIV_LATENCY + 1;

  localparam int DIV_CTRL_UNSIGNED_BIT = 0;
  localparam int DIV_CTRL_REM_BIT      = 1;
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [1:0]  div_control;
  } id_div_inf_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [1:0]  div_control;
  } ix_div_inf_t;

  function automatic ix_div_inf_t to_ix(id_div_inf_t f);
    ix_div_inf_t x;
    x.rd          = f.rd;
    x.rs1         = f.rs1;
    x.rs2         = f.rs2;
    x.div_control = f.div_control;
    return x;
  endfunction

endpackage

// File: rtl/div_inflight_tracker.sv
// rtl/div_inflight_tracker.sv - valid/rd shift pipe covering issue through WB, with busy mask and count
module div_inflight_tracker
  import div_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [4:0]  push_rd,
  input  logic        squash_head,
  output logic [31:0] busy_mask,
  output logic [4:0]  inflight
);

  logic [DIV_DEPTH-1:0]      valid_q, valid_d;
  logic [DIV_DEPTH-1:0][4:0] rd_q, rd_d;

  always_comb begin
    valid_d    = {valid_q[DIV_DEPTH-2:0], push};
    // A squashed head keeps its slot but stops counting once it leaves stage 0.
    valid_d[1] = valid_q[0] & ~squash_head;
    rd_d       = {rd_q[DIV_DEPTH-2:0], push_rd};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    busy_mask = '0;
    inflight  = '0;
    for (int i = 0; i < DIV_DEPTH; i++) begin
      if (valid_q[i]) begin
        busy_mask[rd_q[i]] = 1'b1;
        inflight           = inflight + 5'd1;
      end
    end
    busy_mask[0] = 1'b0;
  end

endmodule

// File: rtl/div_issue.sv
// rtl/div_issue.sv - divide issue controller: RAW stall, stage-0 issue register, optional DIV_ISSUE_STATS_EN counter
module div_issue
  import div_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_do_branch,
  input  logic        id_div_valid,
  input  id_div_inf_t id_div_inf,
  output logic        id_div_ready,
  output logic        ix_div_valid,
  output ix_div_inf_t ix_div_inf,
  output logic [31:0] div_busy_mask,
  output logic [4:0]  div_inflight
`ifdef DIV_ISSUE_STATS_EN
  ,
  output logic [31:0] div_stall_cycles
`endif
);

  logic        hazard;
  logic        accept;
  logic        ix_valid_q, ix_valid_d;
  ix_div_inf_t ix_inf_q, ix_inf_d;

  always_comb begin
    hazard = ((id_div_inf.rs1_idx != 5'd0) && div_busy_mask[id_div_inf.rs1_idx]) ||
             ((id_div_inf.rs2_idx != 5'd0) && div_busy_mask[id_div_inf.rs2_idx]);
    id_div_ready = !hazard && !wb_do_branch;
    accept       = id_div_valid && id_div_ready;
    ix_valid_d   = accept;
    ix_inf_d     = accept ? to_ix(id_div_inf) : ix_inf_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ix_valid_q <= 1'b0;
      ix_inf_q   <= '0;
    end else begin
      ix_valid_q <= ix_valid_d;
      ix_inf_q   <= ix_inf_d;
    end
  end

  assign ix_div_valid = ix_valid_q;
  assign ix_div_inf   = ix_inf_q;

  // wb_do_branch only kills whatever stage 0 holds; older ops still complete.
  div_inflight_tracker u_tracker (
    .clk         (clk),
    .rst         (rst),
    .push        (accept),
    .push_rd     (id_div_inf.rd),
    .squash_head (wb_do_branch),
    .busy_mask   (div_busy_mask),
    .inflight    (div_inflight)
  );

`ifdef DIV_ISSUE_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (id_div_valid && hazard && !wb_do_branch && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign div_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_div_issue.sv
// tb/tb_div_issue.sv - self-checking bench for div_issue against an op-list reference model
`timescale 1ns/1ps
module tb_div_issue;
  import div_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_do_branch = 1'b0;
  logic        id_div_valid = 1'b0;
  id_div_inf_t id_div_inf = '0;
  logic        id_div_ready;
  logic        ix_div_valid;
  ix_div_inf_t ix_div_inf;
  logic [31:0] div_busy_mask;
  logic [4:0]  div_inflight;
`ifdef DIV_ISSUE_STATS_EN
  logic [31:0] div_stall_cycles;
`endif

  always #5 clk = ~clk;

  div_issue dut (
    .clk          (clk),
    .rst          (rst),
    .wb_do_branch (wb_do_branch),
    .id_div_valid (id_div_valid),
    .id_div_inf   (id_div_inf),
    .id_div_ready (id_div_ready),
    .ix_div_valid (ix_div_valid),
    .ix_div_inf   (ix_div_inf),
    .div_busy_mask(div_busy_mask),
    .div_inflight (div_inflight)
`ifdef DIV_ISSUE_STATS_EN
    ,
    .div_stall_cycles(div_stall_cycles)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int s_cyc;
  logic        s_ready, s_ixv;
  logic [31:0] s_mask;
  logic [4:0]  s_infl;

  // Reference: every accepted op is alive from acc+1 to acc+1+DIV_LATENCY,
  // or only at acc+1 if a branch hit it while it sat on the issue port.
  typedef struct {
    int          acc;
    id_div_inf_t inf;
    bit          sq;
  } op_t;
  op_t   ops[$];
  longint stall_exp = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic id_div_inf_t mk(input logic [4:0] rd, input logic [4:0] r1,
                                     input logic [4:0] r2, input logic [1:0] c);
    id_div_inf_t f;
    f.rd = rd; f.rs1_idx = r1; f.rs2_idx = r2; f.div_control = c;
    f.rs1 = $urandom; f.rs2 = $urandom;
    return f;
  endfunction

  function automatic void model(input int t, output logic [31:0] m, output int n,
                                output logic v, output id_div_inf_t f);
    m = '0; n = 0; v = 1'b0; f = '0;
    foreach (ops[i]) begin
      int a;
      a = ops[i].acc;
      if (t >= a + 1 && t <= a + 1 + DIV_LATENCY && !(ops[i].sq && t > a + 1)) begin
        n++;
        if (ops[i].inf.rd != 5'd0) m[ops[i].inf.rd] = 1'b1;
      end
      if (t == a + 1) begin v = 1'b1; f = ops[i].inf; end
    end
  endfunction

  task automatic step(input logic v, input id_div_inf_t f, input logic br);
    logic [31:0] m;
    int          n;
    logic        xv, hz, rdy;
    id_div_inf_t xf;
    id_div_valid = v; id_div_inf = f; wb_do_branch = br;
    foreach (ops[i]) if (ops[i].acc + 1 == cyc && br) ops[i].sq = 1'b1;
    model(cyc, m, n, xv, xf);
    hz  = (f.rs1_idx != 0 && m[f.rs1_idx]) || (f.rs2_idx != 0 && m[f.rs2_idx]);
    rdy = !hz && !br;
    @(negedge clk);
    s_cyc = cyc; s_ready = id_div_ready; s_ixv = ix_div_valid;
    s_mask = div_busy_mask; s_infl = div_inflight;
    chk("id_div_ready", 128'(id_div_ready), 128'(rdy));
    chk("div_busy_mask", 128'(div_busy_mask), 128'(m));
    chk("div_inflight", 128'(div_inflight), 128'(n));
    chk("ix_div_valid", 128'(ix_div_valid), 128'(xv));
    if (xv) chk("ix_div_inf", 128'(ix_div_inf), 128'(to_ix(xf)));
`ifdef DIV_ISSUE_STATS_EN
    chk("div_stall_cycles", 128'(div_stall_cycles), 128'(stall_exp));
`endif
    if (v && hz && !br && stall_exp != 64'hFFFF_FFFF) stall_exp++;
    if (v && rdy) ops.push_back('{cyc, f, 1'b0});
    while (ops.size() > 0 && ops[0].acc + DIV_LATENCY + 3 < cyc) void'(ops.pop_front());
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, '0, 1'b0);
  endtask

  typedef struct {
    logic        v;
    id_div_inf_t f;
    logic        e_rdy, e_ixv;
    logic [4:0]  e_infl;
    logic [31:0] e_mask;
  } vec_t;
  vec_t vecs[22];

  initial begin
    // DIV x5=x1/x2 at cycle 0, then REM x6=x5%x3 held from cycle 1 until accepted.
    for (int c = 0; c < 22; c++) begin
      vecs[c].v      = (c <= 20);
      vecs[c].f      = (c == 0) ? mk(5'd5, 5'd1, 5'd2, DIV_OP_DIV) :
                       (c <= 20) ? mk(5'd6, 5'd5, 5'd3, DIV_OP_REM) : id_div_inf_t'('0);
      vecs[c].e_rdy  = (c == 0) || (c >= 20);
      vecs[c].e_ixv  = (c == 1) || (c == 21);
      vecs[c].e_infl = ((c >= 1 && c <= 19) || c == 21) ? 5'd1 : 5'd0;
      vecs[c].e_mask = ((c >= 1 && c <= 19) ? 32'h20 : 32'h0) | ((c == 21) ? 32'h40 : 32'h0);
    end

    @(negedge clk);
    chk("rst_ready", 128'(id_div_ready), 128'(1'b1));
    chk("rst_ix_valid", 128'(ix_div_valid), 128'(1'b0));
    chk("rst_ix_inf", 128'(ix_div_inf), 128'(0));
    chk("rst_mask", 128'(div_busy_mask), 128'(0));
    chk("rst_inflight", 128'(div_inflight), 128'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    cyc = 0;

    for (int c = 0; c < 22; c++) begin
      step(vecs[c].v, vecs[c].f, 1'b0);
      chk("tbl_ready", 128'(s_ready), 128'(vecs[c].e_rdy));
      chk("tbl_ix_valid", 128'(s_ixv), 128'(vecs[c].e_ixv));
      chk("tbl_inflight", 128'(s_infl), 128'(vecs[c].e_infl));
      chk("tbl_mask", 128'(s_mask), 128'(vecs[c].e_mask));
    end
`ifdef DIV_ISSUE_STATS_EN
    chk("tbl_stall_count", 128'(div_stall_cycles), 128'(19));
`endif
    idle(22);

    for (int i = 0; i < 25; i++) begin
      step(1'b1, mk(5'((10 + i) % 32), 5'd0, 5'd0, DIV_OP_DIVU), 1'b0);
      chk("b2b_ready", 128'(s_ready), 128'(1'b1));
      chk("b2b_mask_bit0", 128'(s_mask[0]), 128'(1'b0));
      if (i >= 19) chk("b2b_inflight_sat", 128'(s_infl), 128'(19));
    end
    idle(22);

    begin
      int k;
      k = cyc;
      step(1'b1, mk(5'd8, 5'd0, 5'd0, DIV_OP_DIV), 1'b0);
      idle(4);
      step(1'b1, mk(5'd7, 5'd0, 5'd0, DIV_OP_REMU), 1'b0);
      step(1'b1, mk(5'd9, 5'd0, 5'd0, DIV_OP_DIV), 1'b1);
      chk("br_ready_low", 128'(s_ready), 128'(1'b0));
      chk("br_ix_valid", 128'(s_ixv), 128'(1'b1));
      chk("br_mask7_set", 128'(s_mask[7]), 128'(1'b1));
      while (cyc <= k + 21) begin
        step(1'b0, '0, 1'b0);
        chk("br_mask7_clear", 128'(s_mask[7]), 128'(1'b0));
        chk("br_mask8", 128'(s_mask[8]), 128'(s_cyc <= k + 19));
      end
    end

    step(1'b1, mk(5'd0, 5'd0, 5'd0, DIV_OP_DIV), 1'b0);
    step(1'b1, mk(5'd12, 5'd0, 5'd0, DIV_OP_DIV), 1'b0);
    chk("x0_no_stall", 128'(s_ready), 128'(1'b1));
    chk("x0_mask_bit0", 128'(s_mask[0]), 128'(1'b0));
    idle(21);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 2'($urandom)), ($urandom_range(0, 99) < 8));
    end
    idle(21);

    for (int i = 0; i < 10; i++) step(1'b1, mk(5'(20 + i), 5'd0, 5'd0, DIV_OP_DIV), 1'b0);
    id_div_valid = 1'b0; id_div_inf = '0;
    #2;
    chk("pre_rst_inflight", 128'(div_inflight), 128'(10));
    rst = 1'b0;
    #1;
    chk("arst_ready", 128'(id_div_ready), 128'(1'b1));
    chk("arst_ix_valid", 128'(ix_div_valid), 128'(1'b0));
    chk("arst_ix_inf", 128'(ix_div_inf), 128'(0));
    chk("arst_mask", 128'(div_busy_mask), 128'(0));
    chk("arst_inflight", 128'(div_inflight), 128'(0));
`ifdef DIV_ISSUE_STATS_EN
    chk("arst_stall", 128'(div_stall_cycles), 128'(0));
`endif
    ops.delete();
    stall_exp = 0;
    @(posedge clk); #1;
    cyc++;
    rst = 1'b1;
    step(1'b1, mk(5'd21, 5'd21, 5'd0, DIV_OP_REM), 1'b0);
    chk("post_rst_accept", 128'(s_ready), 128'(1'b1));
    step(1'b0, '0, 1'b0);
    chk("post_rst_ix_valid", 128'(s_ixv), 128'(1'b1));
    idle(21);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_issue.md
# div_issue

Issue-side controller for the pipelined divider execution unit. It sits between decode (ID) and the divider, and accepts decoded DIV/DIVU/REM/REMU operations through a valid/ready handshake. It tracks every operation in flight through the fixed-latency divider, stalls ID on RAW hazards against pending divide destinations, and drives the issue interface that the divider consumes. It also exports a pending-destination mask so other issue logic can honour divide results.

## Interface
- DIV_LATENCY, 18, cycles from ix_div_valid high to the matching div_valid high at WB.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- wb_do_branch  in  1  WB redirect; squashes the op currently presented on ix_div_*.
- id_div_valid  in  1  ID presents a divide op.
- id_div_inf  in  id_div_inf_t  fields:
  - rd[4:0]
  - rs1_idx[4:0], rs2_idx[4:0]
  - rs1[31:0], rs2[31:0]
  - div_control[1:0]: bit0 = unsigned, bit1 = REM.
- id_div_ready  out  1  op accepted this cycle when high together with id_div_valid.
- ix_div_valid  out  1  registered issue valid to the divider.
- ix_div_inf  out  ix_div_inf_t  registered rd, rs1, rs2, div_control.
- div_busy_mask  out  32  bit r set while a divide writing xr is in flight; bit 0 is always 0.
- div_inflight  out  5  number of valid tracked ops, 0..DIV_LATENCY+1.
- div_stall_cycles  out  32  present only with DIV_ISSUE_STATS_EN.

## Operation
- Tracker: a shift pipe of DEPTH = DIV_LATENCY+1 entries, each holding {valid, rd}, advanced every cycle.
  - Stage 0 is the ix_div_* output register.
  - Stage DEPTH-1 is the WB cycle. The entry leaving it retires.
- div_busy_mask is the OR of decode(rd) over valid entries with rd≠0, taken across all stages including stage 0 and the WB stage.
- hazard = (rs1_idx≠0 && mask[rs1_idx]) || (rs2_idx≠0 && mask[rs2_idx]).
- id_div_ready = !hazard && !wb_do_branch. This is combinational and has no dependency on id_div_valid.
- On accept, stage 0 loads valid = 1 and id_div_inf fields. Otherwise stage 0 loads valid = 0; ix_div_inf data is don't-care.
- WAW against an in-flight rd is not a hazard. Ordering is guaranteed by the fixed latency.
- Branch squash: if wb_do_branch is high while ix_div_valid is high, the divider drops that op. Stage 0's entry advances into stage 1 with valid = 0. Entries in stages ≥1 are unaffected because they still complete.
- rd = x0 ops are issued and counted in div_inflight, but never set a mask bit.
- Reset (asynchronous, rst low):
  - All entries are invalid.
  - ix_div_valid = 0, ix_div_inf = 0.
  - div_busy_mask = 0, div_inflight = 0, div_stall_cycles = 0.
  - id_div_ready then follows its equation, which gives 1 when wb_do_branch = 0.

## Timing
- Accept at the edge ending cycle c: ix_div_valid is high in cycle c+1, and div_valid is high at WB in cycle c+1+DIV_LATENCY.
- The mask bit for rd is set from cycle c+1 through c+1+DIV_LATENCY inclusive, and clears in cycle c+2+DIV_LATENCY.
- A dependent op is stalled through the WB cycle. It is accepted at the earliest in the first cycle after the bit clears.
- Throughput is one op per cycle. div_inflight saturates naturally at DEPTH under back-to-back issue.
- Cycle of a wb_do_branch squash:
  - Stage 0 still drives the squashed op, so ix_div_valid is high and its rd bit is set.
  - From the next cycle, that entry no longer contributes to the mask or to div_inflight.

## Configuration
- DIV_ISSUE_STATS_EN defined:
  - div_stall_cycles increments every cycle in which id_div_valid && hazard && !wb_do_branch.
  - It saturates at 32'hFFFF_FFFF and resets to 0.
- DIV_ISSUE_STATS_EN undefined: the port and the counter are absent.

## Structure
- Shared package (defines):
  - id_div_inf_t and ix_div_inf_t.
  - Localparam DIV_LATENCY = 18, shared with the divider so the two cannot diverge.
  - div_control bit encodings.
- Sub-module div_inflight_tracker:
  - Owns the valid/rd shift pipe, mask generation and inflight count.
  - Inputs: push, push_rd, squash_head.
- The top-level block holds the handshake, the stage-0 output register and the stats counter.

## Test plan
- Single DIV x5 = x1/x2, accepted at cycle 0:
  - ix_div_valid high in cycle 1 only.
  - div_busy_mask[5] high in cycles 1–19, low in cycle 20.
  - div_inflight returns to 0 in cycle 20.
- REM x6 = x5 % x3 presented in cycle 1, right after that DIV:
  - id_div_ready low in cycles 1–19, high in cycle 20.
  - ix_div_valid high in cycle 21. With stats enabled, div_stall_cycles = 19.
- 25 independent ops (rd x10..x34 mod 32, rs = x0) back-to-back:
  - Accepted every cycle.
  - div_inflight reaches 19 in cycle 19 and holds.
  - The mask never sets bit 0.
- wb_do_branch high in cycle 1 while ix_div_valid carries rd = x7, and older op rd = x8 is in stage 5:
  - id_div_ready is low in cycle 1.
  - mask[7] clears in cycle 2; mask[8] stays set until its WB cycle.
- Op with rs1_idx = 0 while an in-flight x0-destination op exists: no stall; id_div_ready stays high.
- rst low mid-flight with 10 entries valid:
  - All outputs return to their reset values immediately, without waiting for a clock edge.
  - After release, the first op is accepted in the first cycle id_div_valid is high.
